// File: rtl/sar_magnitude_search.sv
// Successive-approximation search for the A operand of an external magnitude
// comparator: drives its B operand one bit per cycle, MSB first.
module sar_magnitude_search #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             less,
   input  logic             equal,
   input  logic             greater,
   output logic [WIDTH-1:0] trial,
   output logic [WIDTH-1:0] result,
   output logic             busy,
   output logic             done,
   output logic             err
);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_TEST   = 2'd1,
      S_FINISH = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] trial_q, trial_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [IW-1:0]    index_q, index_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;
   logic             one_hot;
   logic [WIDTH-1:0] bit_mask;
   logic [WIDTH-1:0] kept;

   // Exactly one comparator flag may be high; anything else is a broken response.
   assign one_hot  = (less ^ equal ^ greater) & ~(less & equal & greater);
   assign bit_mask = WIDTH'(1) << index_q;
   assign kept     = greater ? trial_q : (trial_q & ~bit_mask);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         trial_q  <= '0;
         result_q <= '0;
         index_q  <= IW'(WIDTH - 1);
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         trial_q  <= trial_d;
         result_q <= result_d;
         index_q  <= index_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (start) state_d = S_TEST;
         end
         S_TEST: begin
            if (!one_hot)             state_d = S_IDLE;
            else if (equal)           state_d = S_FINISH;
            else if (index_q == '0)   state_d = less ? S_FINISH : S_IDLE;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      trial_d  = trial_q;
      result_d = result_q;
      index_d  = index_q;
      err_d    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               trial_d = WIDTH'(1) << (WIDTH - 1);
               index_d = IW'(WIDTH - 1);
            end
         end
         S_TEST: begin
            if (!one_hot) begin
               err_d    = 1'b1;
               result_d = '0;
            end else if (equal) begin
               result_d = trial_q;
            end else if (index_q == '0) begin
               // greater at the last bit means A lies above every remaining candidate
               if (less) begin
                  result_d = trial_q & ~bit_mask;
               end else begin
                  err_d    = 1'b1;
                  result_d = '0;
               end
            end else begin
               trial_d = kept | (bit_mask >> 1);
               index_d = index_q - IW'(1);
            end
         end
         default: ;
      endcase
      busy_d = (state_d == S_TEST);
      done_d = (state_d == S_FINISH);
   end

   assign trial  = trial_q;
   assign result = result_q;
   assign busy   = busy_q;
   assign done   = done_q;
   assign err    = err_q;
endmodule

// File: tb/tb_sar_magnitude_search.sv
// Scoreboard bench for sar_magnitude_search: a behavioural comparator model
// answers the DUT, and a monitor checks each completion against queued expectations.
module tb_sar_magnitude_search;
   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         less, equal, greater;
   logic [W-1:0] trial, result;
   logic         busy, done, err;

   logic [W-1:0] a_val;
   int           fault;
   int           tcnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      int a;
      int res;
      int err;
      int k;
   } exp_t;
   exp_t q[$];

   sar_magnitude_search #(.WIDTH(W)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .less(less), .equal(equal), .greater(greater),
      .trial(trial), .result(result), .busy(busy), .done(done), .err(err)
   );

   always #5 clk = ~clk;

   // Comparator model with optional corrupted responses.
   always_comb begin
      less    = (a_val < trial);
      equal   = (a_val == trial);
      greater = (a_val > trial);
      if (fault == 1 && busy && tcnt == 1) begin
         less = 1'b1; equal = 1'b0; greater = 1'b1;
      end
      if (fault == 2 && busy && tcnt == W - 1) begin
         less = 1'b0; equal = 1'b0; greater = 1'b1;
      end
   end

   always @(posedge clk) begin
      if (busy) tcnt <= tcnt + 1;
      else      tcnt <= 0;
   end

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // A binary search on an unsigned value stops as soon as the trial (prefix + one 1-bit)
   // equals A, i.e. at the step that places A's lowest set bit.
   function automatic int exp_k(input int a);
      if (a == 0) return W;
      for (int b = 0; b < W; b++) if (a[b]) return W - b;
      return W;
   endfunction

   // Trial on step i: A's top i-1 bits, then a 1, then zeros.
   function automatic int exp_trial(input int a, input int step);
      int s;
      s = W - step + 1;
      return ((a >> s) << s) | (1 << (W - step));
   endfunction

   int  bcnt = 0;
   bit  pend = 0;
   always @(negedge clk) begin
      if (!rst_n) begin
         bcnt = 0;
         pend = 0;
      end else begin
         if (pend) begin
            chk("pulse_width", int'({done, err}), 0);
            pend = 0;
         end
         if (busy) begin
            if (q.size() > 0) chk("trial", int'(trial), exp_trial(q[0].a, bcnt + 1));
            bcnt++;
         end
         if (done || err) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_end: done=%0d err=%0d with nothing pending", done, err);
            end else begin
               exp_t e;
               e = q.pop_front();
               chk("result", int'(result), e.res);
               chk("err", int'(err), e.err);
               chk("done", int'(done), 1 - e.err);
               chk("test_cycles", bcnt, e.k);
               chk("busy_at_end", int'(busy), 0);
            end
            bcnt = 0;
            pend = 1;
         end
      end
   end

   task automatic run(input int a, input int f, input bit hold, input bit push);
      exp_t e;
      bit   ended;
      @(negedge clk);
      a_val = W'(a);
      fault = f;
      start = 1'b1;
      if (push) begin
         e.a   = a;
         e.k   = (f == 1) ? 2 : exp_k(a);
         e.err = (f != 0) ? 1 : 0;
         e.res = (f != 0) ? 0 : a;
         q.push_back(e);
      end
      @(negedge clk);
      if (!hold) start = 1'b0;
      ended = 0;
      for (int i = 0; i < 40; i++) begin
         if (done || err) begin
            ended = 1;
            break;
         end
         @(negedge clk);
      end
      start = 1'b0;
      if (!ended) chk("end_timeout", 0, 1);
      @(negedge clk);
      fault = 0;
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      a_val = '0;
      fault = 0;
      #12;
      chk("rst_trial", int'(trial), 0);
      chk("rst_result", int'(result), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      @(negedge clk);
      rst_n = 1'b1;

      run(11, 0, 0, 1);
      run(0, 0, 0, 1);
      run(8, 0, 0, 1);

      for (int a = 0; a < 16; a++) run(a, 0, 1, 1);

      run(6, 1, 0, 1);
      run(9, 0, 0, 1);
      run(0, 2, 0, 1);

      // Asynchronous reset during the third TEST cycle aborts the search.
      @(negedge clk);
      a_val = 4'd9;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 20 && !(busy && tcnt == 2); i++) @(negedge clk);
      chk("reach_third_test", int'(busy && tcnt == 2), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_trial", int'(trial), 0);
      chk("abort_result", int'(result), 0);
      chk("abort_busy", int'(busy), 0);
      chk("abort_done", int'(done), 0);
      chk("abort_err", int'(err), 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      run(5, 0, 0, 1);

      for (int n = 0; n < 24; n++) run(int'($urandom_range(0, 15)), 0, bit'($urandom_range(0, 1)), 1);

      for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
      if (q.size() != 0) chk("pending_left", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
